tt_driver: RTL and testbench

TT_DRIVER -- requirements
Module: tt_driver

---
 rtl/tt_driver.sv | 158 +++++++++++++++
 tb/tb_tt_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_driver.sv
// tt_driver: sweeps the 2-input truth table into an AND gate under test,
// holds each vector for DWELL cycles, samples the gate result in the last
// cycle of each vector and reports a saturating mismatch count and a verdict.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; a/b low, verdict from last run held
// DRIVE  | vector on a/b, settling for DWELL-1 cycles
// SAMPLE | last cycle of the vector; c is compared against a & b
// DONE   | one-cycle done pulse with the final verdict
module tt_driver #(
  parameter int DWELL    = 4,
  parameter int N_PASSES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // DRIVE occupies DWELL-1 cycles, so the down-counter is loaded with
  // DWELL-2 and DRIVE exits when it reaches zero.
  localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 2);
  localparam logic [3:0] PASS_LAST  = 4'(N_PASSES - 1);

  state_t     state, state_nxt;
  logic [7:0] dwell_cnt, dwell_nxt;
  logic [3:0] pass_cnt, pass_cnt_nxt;
  logic [1:0] vec_nxt;
  logic [2:0] err_nxt;
  logic       a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;

  logic       mismatch;
  logic [2:0] err_inc;
  logic [1:0] vec_inc;
  logic       last_vec;

  // Sample-cycle helpers: saturating error increment and end-of-run detect.
  always_comb begin
    mismatch = (c != (a & b));
    err_inc  = (mismatch && (err_cnt != 3'd7)) ? err_cnt + 3'd1 : err_cnt;
    vec_inc  = vec_idx + 2'd1;
    last_vec = (vec_idx == 2'd3) && (pass_cnt == PASS_LAST);
  end

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    state_nxt    = state;
    dwell_nxt    = dwell_cnt;
    pass_cnt_nxt = pass_cnt;
    vec_nxt      = vec_idx;
    err_nxt      = err_cnt;
    a_nxt        = a;
    b_nxt        = b;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    pass_nxt     = pass;

    unique case (state)
      IDLE: begin
        a_nxt    = 1'b0;
        b_nxt    = 1'b0;
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt    = DRIVE;
          dwell_nxt    = DWELL_LOAD;
          pass_cnt_nxt = 4'd0;
          vec_nxt      = 2'd0;
          err_nxt      = 3'd0;
          pass_nxt     = 1'b0;
          busy_nxt     = 1'b1;
        end
      end

      DRIVE: begin
        if (dwell_cnt == 8'd0) begin
          state_nxt = SAMPLE;
        end else begin
          dwell_nxt = dwell_cnt - 8'd1;
        end
      end

      SAMPLE: begin
        err_nxt = err_inc;
        if (last_vec) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_inc == 3'd0);
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          vec_nxt   = 2'd0;
        end else begin
          state_nxt = DRIVE;
          dwell_nxt = DWELL_LOAD;
          vec_nxt   = vec_inc;
          a_nxt     = vec_inc[1];
          b_nxt     = vec_inc[0];
          if (vec_idx == 2'd3) begin
            pass_cnt_nxt = pass_cnt + 4'd1;
          end
        end
      end

      DONE: begin
        // start is deliberately not looked at here; a new run can only be
        // accepted from IDLE on the following cycle.
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any run without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dwell_cnt <= 8'd0;
      pass_cnt  <= 4'd0;
      vec_idx   <= 2'd0;
      err_cnt   <= 3'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      pass_cnt  <= pass_cnt_nxt;
      vec_idx   <= vec_nxt;
      err_cnt   <= err_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
    end
  end

endmodule

// File: tb/tb_tt_driver.sv
// Bench for tt_driver: three instances with different DWELL/N_PASSES, a
// gate model on c, a scoreboard of expected run results and a per-cycle
// monitor that checks the vector schedule and the end-of-run verdict.
module tb_tt_driver;

  typedef struct {
    int st;    // clock edge that samples start
    int err;   // expected err_cnt at done
    bit pas;   // expected pass at done
  } exp_t;

  logic       clk;
  logic       rst_n [3];
  logic       start [3];
  logic       a     [3];
  logic       b     [3];
  logic       c     [3];
  logic       busy  [3];
  logic       done  [3];
  logic       pass  [3];
  logic [2:0] err_cnt [3];
  logic [1:0] vec_idx [3];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mode  [3];
  bit   noise [3];
  int   last_err  [3];
  bit   last_pass [3];
  exp_t sb [3][$];

  tt_driver #(.DWELL(4), .N_PASSES(1)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .a(a[0]), .b(b[0]), .c(c[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err_cnt[0]), .vec_idx(vec_idx[0]));

  tt_driver #(.DWELL(4), .N_PASSES(4)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .a(a[1]), .b(b[1]), .c(c[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err_cnt[1]), .vec_idx(vec_idx[1]));

  tt_driver #(.DWELL(2), .N_PASSES(1)) dut2 (
    .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .a(a[2]), .b(b[2]), .c(c[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_cnt(err_cnt[2]), .vec_idx(vec_idx[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dw(int i);
    return (i == 2) ? 2 : 4;
  endfunction

  function automatic int np(int i);
    return (i == 1) ? 4 : 1;
  endfunction

  // Gate models: 0 correct AND, 1 stuck-at-0, 2 OR, 3 NAND.
  function automatic logic gate(int m, logic x, logic y);
    case (m)
      0:       return x & y;
      1:       return 1'b0;
      2:       return x | y;
      default: return ~(x & y);
    endcase
  endfunction

  function automatic int mism_per_pass(int m);
    int mm = 0;
    for (int v = 0; v < 4; v++) begin
      logic x, y;
      x = v[1];
      y = v[0];
      if (gate(m, x, y) != (x & y)) mm++;
    end
    return mm;
  endfunction

  function automatic int exp_err(int i, int m);
    int t = mism_per_pass(m) * np(i);
    return (t > 7) ? 7 : t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, expv);
    end
  endtask

  // Monitor: checks the schedule of the front scoreboard entry, pops it at
  // done, and drives c from the gate model (noise outside sample cycles).
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      int  d, tot, j, v;
      bit  inrun, smp;
      d     = dw(g);
      tot   = 4 * d * np(g);
      inrun = (sb[g].size() != 0) && (cyc >= sb[g][0].st);
      j     = inrun ? cyc - sb[g][0].st : 0;
      smp   = inrun && (j < tot) && ((j % d) == d - 1);
      if (inrun) begin
        if (j < tot) begin
          v = (j / d) % 4;
          chk($sformatf("busy%0d", g), busy[g], 1);
          chk($sformatf("done_early%0d", g), done[g], 0);
          chk($sformatf("vec_idx%0d", g), vec_idx[g], v);
          chk($sformatf("a%0d", g), a[g], (v >> 1) & 1);
          chk($sformatf("b%0d", g), b[g], v & 1);
        end else begin
          chk($sformatf("done%0d", g), done[g], 1);
          chk($sformatf("busy_at_done%0d", g), busy[g], 0);
          chk($sformatf("err_cnt%0d", g), err_cnt[g], sb[g][0].err);
          chk($sformatf("pass%0d", g), pass[g], sb[g][0].pas);
          last_err[g]  = sb[g][0].err;
          last_pass[g] = sb[g][0].pas;
          void'(sb[g].pop_front());
        end
      end else begin
        chk($sformatf("busy_idle%0d", g), busy[g], 0);
        chk($sformatf("done_idle%0d", g), done[g], 0);
        chk($sformatf("err_hold%0d", g), err_cnt[g], last_err[g]);
        chk($sformatf("pass_hold%0d", g), pass[g], last_pass[g]);
      end
      if (noise[g] && !smp) c[g] = 1'($urandom);
      else                  c[g] = gate(mode[g], a[g], b[g]);
    end
  end

  task automatic wait_drain(int i);
    int k = 0;
    while (sb[i].size() != 0 && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk($sformatf("drain_timeout%0d", i), sb[i].size(), 0);
    sb[i].delete();
  endtask

  task automatic run(int i, int m, bit nz);
    @(negedge clk);
    #1;
    mode[i]  = m;
    noise[i] = nz;
    sb[i].push_back('{cyc + 1, exp_err(i, m), mism_per_pass(m) == 0});
    start[i] = 1'b1;
    @(negedge clk);
    #1;
    start[i] = 1'b0;
    wait_drain(i);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // Reset in the second vector's DRIVE phase, then a clean run.
  task automatic reset_mid_run();
    int s;
    @(negedge clk);
    #1;
    mode[0]  = 3;
    noise[0] = 1'b1;
    s = cyc + 1;
    sb[0].push_back('{s, exp_err(0, 3), 1'b0});
    start[0] = 1'b1;
    @(negedge clk);
    #1;
    start[0] = 1'b0;
    repeat (dw(0) + 1) @(negedge clk);
    #2;
    chk("err_before_reset", err_cnt[0], 1);
    sb[0].delete();
    rst_n[0] = 1'b0;
    last_err[0]  = 0;
    last_pass[0] = 1'b0;
    #1;
    chk("rst_a", a[0], 0);
    chk("rst_b", b[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_pass", pass[0], 0);
    chk("rst_err", err_cnt[0], 0);
    chk("rst_vec", vec_idx[0], 0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (3) @(negedge clk);
    run(0, 0, 1'b1);
  endtask

  // start held high across a run: second run begins two edges after done.
  task automatic held_start(int i, int m);
    int s, tot;
    tot = 4 * dw(i) * np(i);
    @(negedge clk);
    #1;
    mode[i]  = m;
    noise[i] = 1'b1;
    s = cyc + 1;
    sb[i].push_back('{s, exp_err(i, m), mism_per_pass(m) == 0});
    sb[i].push_back('{s + tot + 2, exp_err(i, m), mism_per_pass(m) == 0});
    start[i] = 1'b1;
    wait_drain(i);
    start[i] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; c[i] = 1'b0;
      mode[i] = 0; noise[i] = 1'b0; last_err[i] = 0; last_pass[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 0, 1'b0);
    run(0, 1, 1'b1);
    run(0, 2, 1'b1);
    reset_mid_run();
    run(1, 3, 1'b1);
    run(1, 0, 1'b1);
    run(1, 2, 1'b1);
    held_start(2, 0);
    held_start(2, 2);
    for (int r = 0; r < 12; r++) begin
      run(r % 3, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got cyc %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
